// File: rtl/control_prog_pkg.sv
// control_prog_pkg: widths, opcode encodings and program word type for the control_prog processor.
package control_prog_pkg;
   localparam int CP_DW = 4;
   localparam int CP_AW = 4;
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDA = 4'h5;
   localparam logic [3:0] OP_LDI = 4'h6;
   localparam logic [3:0] OP_OUT = 4'h7;
   localparam logic [3:0] OP_MOV = 4'h8;
   localparam logic [3:0] OP_JMP = 4'h9;
   localparam logic [3:0] OP_JZ  = 4'hA;
   localparam logic [3:0] OP_JC  = 4'hB;
   localparam logic [3:0] OP_IN  = 4'hC;
   localparam logic [3:0] OP_XOR = 4'hD;
   localparam logic [3:0] OP_NOT = 4'hE;
   localparam logic [3:0] OP_NOP = 4'hF;
   typedef logic [CP_DW+3:0] word_t;
endpackage

// File: rtl/control_prog_alu.sv
// control_prog_alu: arithmetic/logic unit; carry doubles as borrow for SUB.
module control_prog_alu
   import control_prog_pkg::*;
(
   input  logic [3:0]       op,
   input  logic [CP_DW-1:0] a,
   input  logic [CP_DW-1:0] b,
   output logic [CP_DW-1:0] result,
   output logic             carry,
   output logic             zero
);
   logic [CP_DW:0] sum;
   logic [CP_DW:0] diff;
   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      result = op == OP_ADD ? sum[CP_DW-1:0] :
               op == OP_SUB ? diff[CP_DW-1:0] :
               op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_XOR ? a ^ b : ~a;
      carry  = op == OP_SUB ? diff[CP_DW] : sum[CP_DW];
      zero   = result == '0;
   end
endmodule

// File: rtl/control_prog.sv
// control_prog: 4-bit stored-program processor with program/data RAM, A, B, PC and Z/C flags.
// Define CTRL_PROG_HALT_EN to make opcode 1111 a HALT instead of NOP.
module control_prog
   import control_prog_pkg::*;
(
   input  logic             clk,
   input  logic             PC_reset_n,
   input  logic             mem_write,
   input  logic [3:0]       instr,
   input  logic [CP_DW-1:0] portin,
   output logic [CP_DW-1:0] portout
);
   word_t            prog [2**CP_AW];
   logic [CP_DW-1:0] dmem [2**CP_AW];
   logic [CP_AW-1:0] pc_q, pc_d;
   logic [CP_DW-1:0] a_q, a_d, b_q, b_d, portout_q, portout_d;
   logic             z_q, z_d, c_q, c_d;
   word_t            word;
   logic [3:0]       op;
   logic [CP_DW-1:0] k;
   logic [CP_DW-1:0] alu_res;
   logic             alu_c, alu_z, run;

   assign word    = prog[pc_q];
   assign op      = word[CP_DW+3:CP_DW];
   assign k       = word[CP_DW-1:0];
   assign portout = portout_q;

   control_prog_alu u_alu (
      .op     (op),
      .a      (a_q),
      .b      (b_q),
      .result (alu_res),
      .carry  (alu_c),
      .zero   (alu_z)
   );

`ifdef CTRL_PROG_HALT_EN
   logic halt_q, halt_d;
   assign run    = !mem_write && !halt_q;
   assign halt_d = halt_q || (run && op == OP_NOP);
   always_ff @(posedge clk or negedge PC_reset_n)
      if (!PC_reset_n) halt_q <= 1'b0;
      else             halt_q <= halt_d;
`else
   assign run = !mem_write;
`endif

   always_comb begin
      pc_d      = pc_q;
      a_d       = a_q;
      b_d       = b_q;
      z_d       = z_q;
      c_d       = c_q;
      portout_d = portout_q;
      if (mem_write) pc_d = pc_q + 1'b1;
      else if (run) begin
         pc_d = pc_q + 1'b1;
         case (op)
            OP_ADD, OP_SUB: begin a_d = alu_res; z_d = alu_z; c_d = alu_c; end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin a_d = alu_res; z_d = alu_z; end
            OP_LDA: begin a_d = dmem[k]; z_d = dmem[k] == '0; end
            OP_LDI: begin a_d = k; z_d = k == '0; end
            OP_IN:  begin a_d = portin; z_d = portin == '0; end
            OP_OUT: portout_d = a_q;
            OP_MOV: b_d = a_q;
            OP_JMP: pc_d = k;
            OP_JZ:  pc_d = z_q ? k : pc_q + 1'b1;
            OP_JC:  pc_d = c_q ? k : pc_q + 1'b1;
`ifdef CTRL_PROG_HALT_EN
            OP_NOP: pc_d = pc_q;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge PC_reset_n)
      if (!PC_reset_n) begin
         pc_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         z_q       <= 1'b0;
         c_q       <= 1'b0;
         portout_q <= '0;
      end else begin
         pc_q      <= pc_d;
         a_q       <= a_d;
         b_q       <= b_d;
         z_q       <= z_d;
         c_q       <= c_d;
         portout_q <= portout_d;
      end

   // RAMs are never cleared; gating on PC_reset_n drops writes while reset is held
   always_ff @(posedge clk) begin
      if (PC_reset_n && mem_write) prog[pc_q] <= {instr, portin};
      if (PC_reset_n && run && op == OP_STA) dmem[k] <= a_q;
   end
endmodule

// File: tb/tb_control_prog.sv
// tb_control_prog: directed programs for control_prog; expected portout values go through a scoreboard queue.
module tb_control_prog;
   logic       clk = 1'b0;
   logic       PC_reset_n = 1'b1;
   logic       mem_write = 1'b0;
   logic [3:0] instr = '0;
   logic [3:0] portin = '0;
   logic [3:0] portout;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_q[$];
   string      tag_q[$];
   logic [7:0] img[$];

`ifdef CTRL_PROG_HALT_EN
   localparam logic [3:0] HALT_EXP = 4'd5;
`else
   localparam logic [3:0] HALT_EXP = 4'd2;
`endif

   control_prog dut (
      .clk        (clk),
      .PC_reset_n (PC_reset_n),
      .mem_write  (mem_write),
      .instr      (instr),
      .portin     (portin),
      .portout    (portout)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push(input string t, input logic [3:0] e);
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   task automatic pop_check();
      logic [3:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (portout === e) else begin
         errors++;
         $error("FAIL %s: portout=%0d expected %0d", t, portout, e);
      end
   endtask

   task automatic expect_after(input int n, input string t, input logic [3:0] e);
      push(t, e);
      step(n);
      pop_check();
   endtask

   task automatic pulse_reset();
      PC_reset_n = 1'b0;
      #3;
      PC_reset_n = 1'b1;
   endtask

   task automatic load();
      pulse_reset();
      mem_write = 1'b1;
      foreach (img[i]) begin
         {instr, portin} = img[i];
         step(1);
      end
      mem_write = 1'b0;
      pulse_reset();
   endtask

   initial begin
      #2;
      push("reset_state", 4'd0);
      PC_reset_n = 1'b0;
      #1;
      pop_check();
      PC_reset_n = 1'b1;
      step(1);

      img = '{8'h63, 8'h40, 8'h63, 8'h41, 8'h50, 8'h80, 8'h51, 8'h00, 8'h70, 8'h99};
      load();
      expect_after(8, "sum_before_out", 4'd0);
      expect_after(1, "sum_out", 4'd6);
      expect_after(11, "sum_halt_loop", 4'd6);
      push("async_reset", 4'd0);
      PC_reset_n = 1'b0;
      #1;
      pop_check();
      #2;
      PC_reset_n = 1'b1;
      expect_after(8, "rerun_before_out", 4'd0);
      expect_after(1, "rerun_out", 4'd6);

      img = '{8'h6F, 8'h80, 8'h61, 8'h00, 8'hB7, 8'h69, 8'h70, 8'hA9, 8'h69, 8'hE0, 8'h70, 8'h9B};
      load();
      expect_after(7, "carry_jc_early", 4'd0);
      expect_after(1, "carry_jc_jz", 4'd15);

      img = '{8'h65, 8'h80, 8'h63, 8'h10, 8'hB7, 8'h70, 8'h96, 8'hE0, 8'h70, 8'h99};
      load();
      expect_after(6, "borrow_early", 4'd0);
      expect_after(1, "borrow_jc", 4'd1);

      img = '{8'h6C, 8'h80, 8'h6A, 8'hD0, 8'h80, 8'h63, 8'h30, 8'h20, 8'h70, 8'h99};
      load();
      expect_after(8, "logic_early", 4'd0);
      expect_after(1, "logic_out", 4'd6);

      img = '{8'hC0, 8'h70, 8'h92};
      load();
      portin = 4'b1010;
      expect_after(1, "in_before_out", 4'd0);
      expect_after(1, "in_out", 4'b1010);

      img = '{8'h61, 8'h70, 8'h92};
      repeat (13) img.push_back(8'hF0);
      img.push_back(8'h67);
      load();
      expect_after(2, "pc_wrap_overwrite", 4'd7);

      img = '{8'h65, 8'h70, 8'hF0, 8'h62, 8'h70, 8'h95};
      load();
      expect_after(2, "halt_first_out", 4'd5);
      expect_after(3, "halt_second_out", HALT_EXP);
      expect_after(5, "halt_steady", HALT_EXP);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
